// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered adder result stage with NZCV flags, skid buffer and overflow counter
module alu_result_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             ovf_clr,
  output logic [7:0]       ovf_count
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic             in_ready_q, in_ready_d;
  logic [7:0]       ovf_count_q, ovf_count_d;

  logic       accept;
  logic       xfer;
  logic [3:0] beat_flags;

  always_comb begin
    beat_flags = {in_sum[WIDTH-1],
                  (in_sum == '0),
                  in_cout,
                  (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb)};
    accept = in_valid & in_ready_q;
    xfer   = out_valid_q & out_ready;

    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_flags_d  = skid_flags_q;
    ovf_count_d   = ovf_count_q;

    // in_ready is low whenever SKID holds a beat, so accept and skid drain never coincide
    if (skid_valid_q) begin
      if (xfer) begin
        out_result_d = skid_result_q;
        out_flags_d  = skid_flags_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || xfer) begin
        out_valid_d  = 1'b1;
        out_result_d = in_sum;
        out_flags_d  = beat_flags;
      end else begin
        skid_valid_d  = 1'b1;
        skid_result_d = in_sum;
        skid_flags_d  = beat_flags;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;

    if (ovf_clr) begin
      ovf_count_d = 8'd0;
    end else if (accept && beat_flags[0] && (ovf_count_q != 8'hFF)) begin
      ovf_count_d = ovf_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= 4'b0000;
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_flags_q  <= 4'b0000;
      in_ready_q    <= 1'b1;
      ovf_count_q   <= 8'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_flags_q  <= skid_flags_d;
      in_ready_q    <= in_ready_d;
      ovf_count_q   <= ovf_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized and directed bench for alu_result_stage against a queue model
module tb_alu_result_stage;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] result;
    logic [3:0]   flags;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_sum = '0;
  logic         in_cout = 1'b0;
  logic         in_a_msb = 1'b0;
  logic         in_b_msb = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         ovf_clr = 1'b0;
  logic [7:0]   ovf_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dut_acc = 0;
  int n_dut_xfer = 0;

  beat_t      model_q[$];
  int         model_ovf = 0;
  logic [3:0] cur_flags = 4'b0000;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the adder-side inputs for a op b and derive the expected flags from signed/unsigned arithmetic
  task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
    int sa, sb, sres;
    logic [W-1:0] res;
    logic carry;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      sres  = sa - sb;
      res   = a - b;
      carry = (a >= b);
    end else begin
      sres  = sa + sb;
      res   = a + b;
      carry = ((int'(a) + int'(b)) > 65535);
    end
    in_sum    = res;
    in_cout   = carry;
    in_a_msb  = a[W-1];
    in_b_msb  = sub ? ~b[W-1] : b[W-1];
    cur_flags = {res[W-1], res == '0, carry, (sres > 32767) || (sres < -32768)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT against the queue model every cycle, then advance the model by this cycle's edge
  always @(negedge clk) begin
    bit acc, xf;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_flags", out_flags, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_ovf_count", ovf_count, 0);
      model_q.delete();
      model_ovf = 0;
    end else begin
      chk("out_valid", out_valid, model_q.size() > 0);
      chk("in_ready", in_ready, model_q.size() < 2);
      if (model_q.size() > 0) begin
        chk("out_result", out_result, model_q[0].result);
        chk("out_flags", out_flags, model_q[0].flags);
      end
      chk("ovf_count", ovf_count, model_ovf);
      if (in_valid && in_ready) n_dut_acc++;
      if (out_valid && out_ready) n_dut_xfer++;
      acc = in_valid && (model_q.size() < 2);
      xf  = out_ready && (model_q.size() > 0);
      if (xf) void'(model_q.pop_front());
      if (acc) model_q.push_back('{result: in_sum, flags: cur_flags});
      if (ovf_clr) model_ovf = 0;
      else if (acc && cur_flags[0] && model_ovf < 255) model_ovf++;
    end
  end

  initial begin
    int x0, cycles;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 0x7FFF + 0x0001: signed overflow
    out_ready = 1'b1;
    set_beat(16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("d1_valid", out_valid, 1);
    chk("d1_result", out_result, 16'h8000);
    chk("d1_flags", out_flags, 4'b1001);
    chk("d1_ovf", ovf_count, 1);

    // 0xFFFF + 0x0001: zero with carry
    set_beat(16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("d2_result", out_result, 16'h0000);
    chk("d2_flags", out_flags, 4'b0110);
    chk("d2_ovf", ovf_count, 1);
    step();

    // Backpressure: three beats with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(16'h0001, 16'h0002, 1'b0);
    step();
    set_beat(16'h0010, 16'h0020, 1'b0);
    step();
    chk("bp_in_ready_after2", in_ready, 0);
    set_beat(16'h0100, 16'h0200, 1'b0);
    step();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_hold_result", out_result, 16'h0003);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_result, 16'h0030);
    step();
    in_valid = 1'b0;
    chk("bp_third", out_result, 16'h0300);
    step();
    chk("bp_drained", out_valid, 0);

    // Reset with OUT and SKID both occupied
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(16'h1234, 16'h0001, 1'b0);
    step();
    set_beat(16'h2345, 16'h0001, 1'b0);
    step();
    in_valid = 1'b0;
    chk("rm_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_in_ready", in_ready, 1);
    chk("rm_flags", out_flags, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rm_empty_after", out_valid, 0);
    set_beat(16'h4000, 16'h0004, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rm_latency_valid", out_valid, 1);
    chk("rm_latency_result", out_result, 16'h4004);
    out_ready = 1'b1;
    step();

    // Saturation and clear priority
    in_valid = 1'b1;
    set_beat(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 260; i++) step();
    in_valid = 1'b0;
    step();
    chk("sat_255", ovf_count, 255);
    ovf_clr  = 1'b1;
    in_valid = 1'b1;
    step();
    ovf_clr  = 1'b0;
    in_valid = 1'b0;
    chk("clr_prio", ovf_count, 0);
    step();

    // Full throughput with out_ready held high
    x0 = n_dut_xfer;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      set_beat(W'($urandom), W'($urandom), 1'($urandom));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("throughput", n_dut_xfer - x0, 200);

    // Random valid/ready traffic
    x0 = n_dut_acc;
    cycles = 0;
    while ((n_dut_acc - x0) < 10000 && cycles < 60000) begin
      logic [W-1:0] a;
      a = W'($urandom);
      if ($urandom_range(0, 15) == 0) set_beat(a, a, 1'b1);
      else set_beat(a, W'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 199) == 0);
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    chk("random_budget", (n_dut_acc - x0) >= 10000, 1);
    step();
    step();
    step();
    chk("random_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
